// File: rtl/core_frame_loader_if.sv
// Bundle for the frame loader: task-scheduler load port plus pipeline issue port.
// The master is whoever drives frames and accepts instructions; the slave is the loader.
interface core_frame_loader_if #(
    parameter int INSN_W = 32,
    parameter int CNT_W  = 2,
    parameter int REG_W  = 16
);
    logic              Start;
    logic [CNT_W-1:0]  Insn_Load_Counter;
    logic [INSN_W-1:0] Insn_Data;
    logic              Init_R0_En;
    logic [REG_W-1:0]  Init_R0;
    logic              Ready;
    logic              insn_valid;
    logic [INSN_W-1:0] insn;
    logic              insn_ready;
    logic              pipe_idle;
    logic              r0_we;
    logic [REG_W-1:0]  r0_data;
    logic              load_err;

    modport master (
        output Start, Insn_Load_Counter, Insn_Data, Init_R0_En, Init_R0,
               insn_ready, pipe_idle,
        input  Ready, insn_valid, insn, r0_we, r0_data, load_err
    );

    modport slave (
        input  Start, Insn_Load_Counter, Insn_Data, Init_R0_En, Init_R0,
               insn_ready, pipe_idle,
        output Ready, insn_valid, insn, r0_we, r0_data, load_err
    );
endinterface

// File: rtl/core_frame_loader.sv
// Loads a PARTS-word instruction frame in index order, issues it to the pipeline,
// then waits for the pipeline to drain before accepting the next frame.
//
// state | meaning
// IDLE  | ready for word 0 of a new frame
// LOAD  | collecting words 1..PARTS-1, Start may stall
// EXEC  | issuing frame words to the pipeline
// DRAIN | frame issued, waiting for pipe_idle
module core_frame_loader #(
    parameter int PARTS  = 4,
    parameter int INSN_W = 32,
    parameter int CNT_W  = 2,
    parameter int REG_W  = 16
) (
    input logic               clk,
    input logic               reset,
    core_frame_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PARTS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  exp_q, exp_d;
    logic [CNT_W-1:0]  pc_q, pc_d;
    logic              err_q, err_d;
    logic              r0_we_q, r0_we_d;
    logic [REG_W-1:0]  r0_data_q, r0_data_d;
    logic              frame_we;
    logic [INSN_W-1:0] frame_q [PARTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            pc_q      <= '0;
            err_q     <= 1'b0;
            r0_we_q   <= 1'b0;
            r0_data_q <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            r0_we_q   <= r0_we_d;
            r0_data_q <= r0_data_d;
        end
    end

    // Frame storage needs no reset; it is always fully rewritten before issue.
    always_ff @(posedge clk) begin
        if (frame_we) begin
            frame_q[bus.Insn_Load_Counter] <= bus.Insn_Data;
        end
    end

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        pc_d      = pc_q;
        err_d     = err_q;
        r0_we_d   = 1'b0;
        r0_data_d = r0_data_q;
        frame_we  = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                // exp is 0 in IDLE, so word 0 and later words share one check.
                if (bus.Start) begin
                    if (bus.Insn_Load_Counter == exp_q) begin
                        frame_we = 1'b1;
                        exp_d    = exp_q + 1'b1;
                        state_d  = LOAD;
                        if (state_q == IDLE && bus.Init_R0_En) begin
                            r0_we_d   = 1'b1;
                            r0_data_d = bus.Init_R0;
                        end
                        if (exp_q == LAST) begin
                            exp_d   = '0;
                            pc_d    = '0;
                            state_d = EXEC;
                        end
                    end else begin
                        err_d   = 1'b1;
                        exp_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            EXEC: begin
                if (bus.Start) err_d = 1'b1;
                if (bus.insn_ready) begin
                    if (pc_q == LAST) begin
                        pc_d    = '0;
                        state_d = DRAIN;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (bus.Start) err_d = 1'b1;
                if (bus.pipe_idle) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Ready      = (state_q == IDLE) || (state_q == LOAD);
    assign bus.insn_valid = (state_q == EXEC);
    assign bus.insn       = frame_q[pc_q];
    assign bus.r0_we      = r0_we_q;
    assign bus.r0_data    = r0_data_q;
    assign bus.load_err   = err_q;
endmodule

// File: tb/tb_core_frame_loader.sv
// Directed bench for core_frame_loader: loaded words go into a scoreboard queue
// and are popped and compared as the loader issues them.
module tb_core_frame_loader;
    localparam int PARTS = 4, INSN_W = 32, CNT_W = 2, REG_W = 16;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [INSN_W-1:0] sb_q[$];

    core_frame_loader_if #(.INSN_W(INSN_W), .CNT_W(CNT_W), .REG_W(REG_W)) bif ();

    core_frame_loader #(.PARTS(PARTS), .INSN_W(INSN_W), .CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic load_word(input int idx, input logic [31:0] data, input bit push);
        bif.Start             = 1'b1;
        bif.Insn_Load_Counter = CNT_W'(idx);
        bif.Insn_Data         = data;
        if (push) sb_q.push_back(data);
        tick();
        bif.Start      = 1'b0;
        bif.Init_R0_En = 1'b0;
    endtask

    task automatic load_frame(input logic [31:0] base);
        for (int i = 0; i < PARTS; i++) load_word(i, base + 32'(i), 1'b1);
    endtask

    task automatic issue_n(input int n);
        logic [31:0] expv;
        bif.insn_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("issue_valid", 32'(bif.insn_valid), 32'd1);
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 32'(sb_q.size()), 32'd1);
            end else begin
                expv = sb_q.pop_front();
                chk("issue_insn", bif.insn, expv);
            end
            tick();
        end
        bif.insn_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        reset = 1'b0;
        bif.Start = 1'b0;
        bif.Insn_Load_Counter = '0;
        bif.Insn_Data = '0;
        bif.Init_R0_En = 1'b0;
        bif.Init_R0 = '0;
        bif.insn_ready = 1'b0;
        bif.pipe_idle = 1'b1;
        #2;
        do_reset();

        chk("rst_ready", 32'(bif.Ready), 32'd1);
        chk("rst_valid", 32'(bif.insn_valid), 32'd0);
        chk("rst_r0_we", 32'(bif.r0_we), 32'd0);
        chk("rst_r0_data", 32'(bif.r0_data), 32'd0);
        chk("rst_err", 32'(bif.load_err), 32'd0);

        // Basic frame with R0 init on the first word.
        bif.Init_R0_En = 1'b1;
        bif.Init_R0    = 16'h1234;
        load_word(0, 32'hA0, 1'b1);
        chk("r0_we_pulse", 32'(bif.r0_we), 32'd1);
        chk("r0_data", 32'(bif.r0_data), 32'h1234);
        chk("ready_in_load", 32'(bif.Ready), 32'd1);
        load_word(1, 32'hA1, 1'b1);
        chk("r0_we_single", 32'(bif.r0_we), 32'd0);
        load_word(2, 32'hA2, 1'b1);
        load_word(3, 32'hA3, 1'b1);
        chk("exec_ready", 32'(bif.Ready), 32'd0);
        issue_n(PARTS);
        chk("drain_ready", 32'(bif.Ready), 32'd0);
        chk("drain_valid", 32'(bif.insn_valid), 32'd0);
        tick();
        chk("idle_ready_u2", 32'(bif.Ready), 32'd1);
        chk("frame1_err", 32'(bif.load_err), 32'd0);

        // Start stall in the middle of a load.
        load_word(0, 32'hB0, 1'b1);
        load_word(1, 32'hB1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", 32'(bif.Ready), 32'd1);
            chk("stall_valid", 32'(bif.insn_valid), 32'd0);
            tick();
        end
        load_word(2, 32'hB2, 1'b1);
        load_word(3, 32'hB3, 1'b1);
        issue_n(PARTS);
        tick();
        chk("stall_err", 32'(bif.load_err), 32'd0);

        // Backpressure at pc=2, then a slow drain.
        load_frame(32'hC0);
        issue_n(2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bif.insn_valid), 32'd1);
            chk("bp_insn", bif.insn, 32'hC2);
            tick();
        end
        bif.pipe_idle = 1'b0;
        issue_n(2);
        for (int i = 0; i < 4; i++) begin
            chk("drain_hold", 32'(bif.Ready), 32'd0);
            tick();
        end
        bif.pipe_idle = 1'b1;
        chk("drain_still", 32'(bif.Ready), 32'd0);
        tick();
        chk("drain_release", 32'(bif.Ready), 32'd1);

        // Reset mid-EXEC at pc=1.
        load_frame(32'hD0);
        issue_n(1);
        do_reset();
        chk("midrst_ready", 32'(bif.Ready), 32'd1);
        chk("midrst_valid", 32'(bif.insn_valid), 32'd0);
        chk("midrst_err", 32'(bif.load_err), 32'd0);

        // Index error: 0 then 2.
        load_word(0, 32'hE0, 1'b0);
        load_word(2, 32'hE2, 1'b0);
        chk("idx_err", 32'(bif.load_err), 32'd1);
        chk("idx_ready", 32'(bif.Ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("idx_noissue", 32'(bif.insn_valid), 32'd0);
            tick();
        end
        chk("idx_sticky", 32'(bif.load_err), 32'd1);
        // After the error the loader must be back in IDLE: word 0 starts a fresh frame.
        load_frame(32'hF0);
        issue_n(PARTS);
        tick();

        // Start during EXEC is flagged and ignored.
        do_reset();
        load_frame(32'h50);
        load_word(0, 32'h99, 1'b0);
        chk("exec_start_err", 32'(bif.load_err), 32'd1);
        chk("exec_start_insn", bif.insn, 32'h50);
        issue_n(PARTS);
        tick();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
